snell_n1_display: RTL
=====================

Name: snell_n1_display

Overview:
- Downstream consumer of the snell_law stage's 4-bit n1 result; drives the board's 4-digit multiplexed seven-segment display.
- Watches n1 for changes and converts each new value to two BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Scans the pattern "n", "1", tens, units across the four digits.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit before the scan advances (minimum 2).
- DIGIT_BLANK_LZ, 1, 1 = blank the tens digit when it is 0; 0 = show a leading "0".

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- n1  input  4  refractive-index result from snell_law, unsigned 0..15
- an  output  4  digit enables, active-low; an[0] = rightmost (units)
- seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}
- tens  output  4  BCD tens of the last converted n1
- units  output  4  BCD units of the last converted n1
- busy  output  1  high while a conversion is in progress

Behaviour:
- Reset, applied at a clock edge while rst=1:
  - tens=0, units=0, busy=0, last_op=0, state=IDLE.
  - Refresh counter=0, digit index=0.
  - an=4'b1111, seg=7'b1111111.
  - Because last_op=0 after reset, n1=0 triggers no conversion.
- Input sampling: n1_q<=n1 every edge. n1 goes to no other logic.
- FSM states: IDLE, SHIFT, DONE. Timing, for n1 changing before edge k:
  - k: n1_q captures the new value.
  - k+1: in IDLE with n1_q != last_op: load shift register {8'b0, n1_q}, last_op<=n1_q, iteration count<=0, busy<=1, go to SHIFT.
  - k+2..k+5: four SHIFT iterations. Each adds 3 to any BCD nibble >=5, then shifts left by 1. After the 4th iteration go to DONE.
  - k+6: tens/units<=BCD nibbles, busy<=0, go to IDLE.
  - Latency from n1 change to tens/units update is exactly 6 edges.
- Mid-conversion change: the in-flight conversion completes on the operand it captured. IDLE then re-detects n1_q != last_op and starts a new conversion on the following edge. No value is lost; intermediate values may be skipped.
- tens/units and the displayed digits hold their previous values while busy=1.
- Refresh scan:
  - The counter runs 0..REFRESH_DIV-1. On reaching REFRESH_DIV-1 it wraps to 0 and the digit index increments mod 4 (3 wraps to 0).
  - an and seg are registered from the digit index: one cycle of latency, and they always change together with no glitch between them.
  - Index 0: an=1110, seg = units.
  - Index 1: an=1101, seg = tens, or blank when tens=0 and DIGIT_BLANK_LZ=1.
  - Index 2: an=1011, seg = "1".
  - Index 3: an=0111, seg = "n".
  - First edge after reset release: an=1110.
- Segment codes {g..a}, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - n=0101011, blank=1111111
- Reset mid-operation: abort the conversion, return to IDLE, apply all reset values. Any partial result is discarded.
- tens is only ever 0 or 1 and units 0..9; BCD nibble values above 9 must never appear.

Test Plan:
- Reset: hold rst 3 cycles -> an=1111, seg=1111111, tens=0, units=0, busy=0. One edge after release -> an=1110, seg=1000000.
- Conversion: n1=11 at edge k -> busy=1 on edges k+1..k+5, busy=0 and tens=1, units=1 at edge k+6. Digit 1 then shows seg=1111001.
- Leading-zero blank: n1=7 with DIGIT_BLANK_LZ=1 -> tens=0, units=7. Digit 1 shows seg=1111111, digit 0 shows seg=1111000. Repeat with DIGIT_BLANK_LZ=0 -> digit 1 shows 1000000.
- Mid-conversion change: n1=11, then n1=15 two edges later -> tens/units=1/1 at k+6, busy goes low for one cycle, then rises again. Final tens=1, units=5 at k+12.
- Scan: REFRESH_DIV=4, n1=15 -> an cycles 1110, 1101, 1011, 0111, each held 4 clocks. seg shows 0010010, 1111001, 1111001, 0101011 respectively, then repeats.
- Reset mid-conversion: n1 changes 0->9, rst asserted at k+3 for 1 cycle -> tens=0, units=0, busy=0. After release with n1 still 9, a new conversion yields units=9 six edges after release.

Source files
------------

// File: rtl/snell_n1_display.sv
// Shows the snell_law n1 result as "n 1 <tens> <units>" on a 4-digit multiplexed seven-segment display.
// n1 is converted to BCD by a 4-iteration double-dabble engine, which runs only when n1 changes.
module snell_n1_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter int DIGIT_BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] n1,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       busy
);
    localparam int               CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_N     = 7'b0101011;
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       n1_q;
    logic [3:0]       last_op;
    logic [11:0]      sr;
    logic [1:0]       iter;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // One double-dabble iteration: correct each BCD nibble, then shift the whole register left.
    function automatic logic [11:0] dd_step(input logic [11:0] s);
        logic [11:0] t;
        t = s;
        if (t[11:8] >= 4'd5) t[11:8] = t[11:8] + 4'd3;
        if (t[7:4] >= 4'd5)  t[7:4]  = t[7:4] + 4'd3;
        dd_step = {t[10:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        n1_q <= n1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (n1_q != last_op) state_nxt = SHIFT;
            SHIFT:   if (iter == 2'd3)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_op <= 4'd0;
            iter    <= 2'd0;
            tens    <= 4'd0;
            units   <= 4'd0;
        end else begin
            case (state)
                IDLE: if (n1_q != last_op) begin
                    last_op <= n1_q;
                    iter    <= 2'd0;
                end
                SHIFT: iter <= iter + 2'd1;
                DONE: begin
                    tens  <= sr[11:8];
                    units <= sr[7:4];
                end
                default: ;
            endcase
        end
    end

    // The shift register is pure data; a reset mid-conversion simply leaves it to be reloaded.
    always_ff @(posedge clk) begin
        case (state)
            IDLE:    if (n1_q != last_op) sr <= {8'b0, n1_q};
            SHIFT:   sr <= dd_step(sr);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // an and seg share one register stage so the digit enable and its pattern switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            case (digit_idx)
                2'd0: begin
                    an  <= 4'b1110;
                    seg <= seg_code(units);
                end
                2'd1: begin
                    an  <= 4'b1101;
                    seg <= (tens == 4'd0 && DIGIT_BLANK_LZ != 0) ? SEG_BLANK : seg_code(tens);
                end
                2'd2: begin
                    an  <= 4'b1011;
                    seg <= seg_code(4'd1);
                end
                default: begin
                    an  <= 4'b0111;
                    seg <= SEG_N;
                end
            endcase
        end
    end

endmodule
